sbentsrc_ctrl: RTL

SBENTSRC_CTRL -- requirements
Module: sbentsrc_ctrl

---
 rtl/sbentsrc_ctrl.sv | 230 +++++++++++++++++++++++
 1 files changed

// File: rtl/sbentsrc_ctrl.sv
// sbentsrc_ctrl
// Controller for a free-running entropy source. It restarts the source, throws
// away a warm-up run of samples and packs the rest into OUT_WIDTH-bit words
// for a valid/ready consumer. A repetition-count health test watches every
// sample the enabled source produces and latches a sticky failure.
//
// Ports
//   i_clk         clock
//   ff_reset      asynchronous, active-high reset
//   i_start       request to (re)start generation (honoured in IDLE and FAIL)
//   i_stop        request to stop generation
//   i_rnd         entropy-source sample, synchronous to i_clk
//   o_src_en      entropy-source enable
//   o_src_reset   entropy-source reset
//   o_data        packed random word, first sample in the MSBs
//   o_valid       o_data valid
//   i_ready       consumer accepts o_data
//   o_busy        high in SRC_RST, WARMUP, COLLECT and HOLD
//   o_health_fail sticky repetition-test failure flag
module sbentsrc_ctrl #(
    parameter int RNG_WIDTH     = 4,
    parameter int OUT_WIDTH     = 32,
    parameter int WARMUP_CYCLES = 64,
    parameter int REP_LIMIT     = 8
) (
    input  logic                 i_clk,
    input  logic                 ff_reset,
    input  logic                 i_start,
    input  logic                 i_stop,
    input  logic [RNG_WIDTH-1:0] i_rnd,
    output logic                 o_src_en,
    output logic                 o_src_reset,
    output logic [OUT_WIDTH-1:0] o_data,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic                 o_busy,
    output logic                 o_health_fail
);

    localparam int N       = OUT_WIDTH / RNG_WIDTH;
    localparam int CNT_MAX = (WARMUP_CYCLES > N) ? WARMUP_CYCLES : N;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int REP_W   = $clog2(REP_LIMIT + 1);

    typedef enum logic [2:0] {
        IDLE,
        SRC_RST,
        WARMUP,
        COLLECT,
        HOLD,
        FAIL
    } state_t;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [REP_W-1:0]       rep_q, rep_d;
    logic [RNG_WIDTH-1:0]   prev_q, prev_d;
    logic [OUT_WIDTH-1:0]   acc_q, acc_d;
    logic [OUT_WIDTH-1:0]   data_q, data_d;
    logic                   valid_q, valid_d;
    logic                   stopPend_q, stopPend_d;
    logic                   health_q, health_d;
    logic                   srcEn_q, srcEn_d;
    logic                   srcRst_q, srcRst_d;
    logic                   busy_q, busy_d;

    logic                   sampling;
    logic [REP_W-1:0]       repNext;
    logic                   repFail;
    logic [OUT_WIDTH-1:0]   accShift;
    logic                   stopNow;

    // Repetition test: a cleared counter (just after SRC_RST) always starts
    // a new run at 1, so the previous-sample value is irrelevant there.
    always_comb begin
        sampling = (state_q == WARMUP) || (state_q == COLLECT) || (state_q == HOLD);
        if ((rep_q == '0) || (i_rnd != prev_q)) begin
            repNext = REP_W'(1);
        end else if (rep_q == REP_W'(REP_LIMIT)) begin
            repNext = rep_q;
        end else begin
            repNext = rep_q + REP_W'(1);
        end
        repFail  = sampling && (repNext == REP_W'(REP_LIMIT));
        accShift = (acc_q << RNG_WIDTH) | OUT_WIDTH'(i_rnd);
        stopNow  = stopPend_q | i_stop;
    end

    // Next-state logic. A health failure takes priority over stop and over
    // the consumer handshake, so a failing source never delivers another word.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rep_d      = rep_q;
        prev_d     = prev_q;
        acc_d      = acc_q;
        data_d     = data_q;
        valid_d    = valid_q;
        stopPend_d = stopPend_q;
        health_d   = health_q;

        if (sampling) begin
            rep_d  = repNext;
            prev_d = i_rnd;
        end

        case (state_q)
            IDLE: begin
                if (i_start && !i_stop) begin
                    state_d = SRC_RST;
                    cnt_d   = '0;
                end
            end
            SRC_RST: begin
                rep_d      = '0;
                prev_d     = '0;
                acc_d      = '0;
                stopPend_d = 1'b0;
                if (cnt_q == '0) begin
                    cnt_d = CNT_W'(1);
                end else begin
                    state_d = WARMUP;
                    cnt_d   = '0;
                end
            end
            WARMUP: begin
                if (repFail) begin
                    state_d = FAIL;
                end else if (i_stop) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_W'(WARMUP_CYCLES - 1)) begin
                    state_d = COLLECT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            COLLECT: begin
                if (repFail) begin
                    state_d = FAIL;
                end else if (i_stop) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    acc_d   = '0;
                end else begin
                    acc_d = accShift;
                    if (cnt_q == CNT_W'(N - 1)) begin
                        state_d = HOLD;
                        data_d  = accShift;
                        valid_d = 1'b1;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            HOLD: begin
                if (repFail) begin
                    state_d = FAIL;
                end else begin
                    stopPend_d = stopNow;
                    if (i_ready) begin
                        valid_d    = 1'b0;
                        stopPend_d = 1'b0;
                        cnt_d      = '0;
                        state_d    = stopNow ? IDLE : COLLECT;
                    end
                end
            end
            FAIL: begin
                if (i_start) begin
                    state_d  = SRC_RST;
                    health_d = 1'b0;
                    cnt_d    = '0;
                end
            end
            default: state_d = IDLE;
        endcase

        if (repFail) begin
            health_d   = 1'b1;
            valid_d    = 1'b0;
            stopPend_d = 1'b0;
        end

        srcEn_d  = (state_d == WARMUP) || (state_d == COLLECT) || (state_d == HOLD);
        srcRst_d = !srcEn_d;
        busy_d   = (state_d != IDLE) && (state_d != FAIL);
    end

    // State and registered outputs; reset acts immediately, in any state.
    always_ff @(posedge i_clk or posedge ff_reset) begin
        if (ff_reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            rep_q      <= '0;
            prev_q     <= '0;
            acc_q      <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            stopPend_q <= 1'b0;
            health_q   <= 1'b0;
            srcEn_q    <= 1'b0;
            srcRst_q   <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rep_q      <= rep_d;
            prev_q     <= prev_d;
            acc_q      <= acc_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            stopPend_q <= stopPend_d;
            health_q   <= health_d;
            srcEn_q    <= srcEn_d;
            srcRst_q   <= srcRst_d;
            busy_q     <= busy_d;
        end
    end

    assign o_src_en      = srcEn_q;
    assign o_src_reset   = srcRst_q;
    assign o_data        = data_q;
    assign o_valid       = valid_q;
    assign o_busy        = busy_q;
    assign o_health_fail = health_q;

endmodule
